add_serial_ctrl: RTL
====================

# add_serial_ctrl

Bit-serial adder controller that time-shares a single 1-bit full-adder slice (two `add1bit_half` instances plus an OR for carry-out) to add two WIDTH-bit operands, one bit per clock, LSB first. It sits between a requesting block and the 1-bit adder datapath. It captures operands on a start handshake, sequences the slice through every bit position with a registered carry, and returns the WIDTH-bit sum and final carry with a one-cycle done pulse.

## Interface
- WIDTH, 4, operand/sum width in bits; legal range 1..32
- CNT_BITS, $clog2(WIDTH)+1, width of the internal bit-index counter (derived, not overridden)

- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while ready=1
- a  in  WIDTH  operand A; captured when start is accepted
- b  in  WIDTH  operand B; captured when start is accepted
- cin  in  1  carry-in; captured when start is accepted
- ready  out  1  high in IDLE only; start is accepted when start&ready at posedge
- busy  out  1  high in RUN and DONE
- sum  out  WIDTH  result register; shifted during RUN, stable otherwise
- cout  out  1  final carry; valid from done, held until next accept
- done  out  1  one-cycle pulse; sum/cout valid

## Operation
- States: IDLE, RUN, DONE. Binary encoding. No other states are reachable; any illegal encoding goes to IDLE.
- IDLE: ready=1, busy=0. On start=1:
  - load a_sh<=a and b_sh<=b
  - carry<=cin, sum<=0, idx<=0
  - go to RUN
- RUN: the slice inputs are a_sh[0], b_sh[0] and carry. Each cycle:
  - sum<={s, sum[WIDTH-1:1]}
  - a_sh>>=1, b_sh>>=1
  - carry<=c_out of the slice
  - idx<=idx+1
  - When idx==WIDTH-1, the last bit is processed and the next state is DONE.
- DONE: done=1 for exactly this cycle; cout=carry. Next state is IDLE unconditionally.
- Slice:
  - ha0(A=a_sh[0], B=b_sh[0]) -> (O=p, C=g0)
  - ha1(A=p, B=carry) -> (O=s, C=g1)
  - c_out=g0|g1
- Arithmetic: {cout,sum} = a+b+cin, modulo 2^(WIDTH+1). No overflow flag.
- start outside IDLE is ignored, with no queuing; operand changes outside IDLE have no effect.
- sum and cout hold their values through DONE and IDLE until the next accepted start clears sum.
- Reset, at any time including mid-RUN, forces these values asynchronously:
  - state=IDLE
  - ready=1, busy=0, done=0
  - sum=0, cout=0, carry=0, idx=0, a_sh=0, b_sh=0
- Any in-flight operation is discarded; no done is produced for it.
- When reset deasserts with start=1, start is accepted at the first posedge with reset low.

## Timing
- Cycle 0 is the posedge at which start&ready are sampled. RUN covers cycles 1..WIDTH, with bit k processed in the cycle ending at posedge k+1. Done is high during cycle WIDTH+1.
- Latency from start to done: WIDTH+1 cycles. ready returns high at cycle WIDTH+2.
- Minimum start-to-start spacing: WIDTH+2 cycles.
- ready, busy and done are decoded from registered state only; there is no combinational path from start.
- WIDTH=1: RUN lasts one cycle, done at cycle 2.
- sum is not a valid partial result during RUN. Consumers qualify it with done or with ready after the first completion.

## Test plan
- WIDTH=4, reset pulse, then a=3, b=5, cin=0, start for 1 cycle -> done at cycle 5, sum=8, cout=0; ready=1 at cycle 6, with sum and cout held.
- WIDTH=4, a=15, b=1, cin=0 -> sum=0, cout=1. Then a=15, b=15, cin=1 -> sum=15, cout=1.
- Start held high continuously with a=2, b=2 -> accepts every 6 cycles (WIDTH+2). Each done shows sum=4, cout=0; no start is accepted while busy=1.
- Operands changed to a=9, b=9 during RUN of 1+1 -> result remains sum=2, cout=0.
- Reset asserted at cycle 2 of a 7+7 operation -> immediately ready=1, sum=0, cout=0, no done. The next 7+7 completes with sum=14, cout=0.
- Exhaustive: WIDTH=4, all a, b, cin (512 cases), checked against the reference model a+b+cin -> zero mismatches. Repeat with WIDTH=1 (8 cases, done at cycle 2).

Source files
------------

// File: rtl/add_serial_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders + OR),
// reused LSB first over WIDTH cycles, with a start/ready handshake and a done pulse.

module add1bit_half (
  input  logic a,
  input  logic b,
  output logic o,
  output logic c
);
  assign o = a ^ b;
  assign c = a & b;
endmodule

module add_serial_ctrl #(
  parameter int WIDTH    = 4,
  parameter int CNT_BITS = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]    a_sh, b_sh;
  logic                carry;
  logic [CNT_BITS-1:0] idx;
  logic                p, g0, s, g1, c_out, last;

  add1bit_half ha0 (.a(a_sh[0]), .b(b_sh[0]), .o(p), .c(g0));
  add1bit_half ha1 (.a(p),       .b(carry),   .o(s), .c(g1));

  assign c_out = g0 | g1;
  assign last  = (idx == CNT_BITS'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake outputs come from the registered state only.
  always_comb begin
    state_nxt = IDLE;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready     = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      RUN: begin
        busy      = 1'b1;
        state_nxt = last ? DONE : RUN;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
            idx   <= '0;
          end
        end
        RUN: begin
          // Shift form works for WIDTH=1, where a [WIDTH-1:1] slice would not.
          sum   <= (sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_out;
          idx   <= idx + 1'b1;
          if (last) cout <= c_out;
        end
        default: ;
      endcase
    end
  end

endmodule
